// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive ends of the link.
//   tx_state_e    : transmitter frame state
//   PARITY_*      : encodings of the parity_type parameter
//   clks_per_bit(): integer-truncated clock cycles per bit period
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : realigns the divider so the next cycle is the first of a bit
//   bit_end : one-cycle pulse on the last cycle of every bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Configurable UART transmitter with a one-entry holding buffer.
// Frame: start bit, data_bits data bits LSB first, optional parity,
// stop_bits stop bits.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   tx_data_in : word to send, captured when start is accepted
//   start      : send request, accepted only while tx_ready=1
//   tx         : registered serial line, idle high
//   tx_active  : a frame is on the line
//   done_tx    : high on the final cycle of the last stop bit
//   tx_ready   : holding buffer empty
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int clk_freq    = 50000000,
    parameter int baud_rate   = 19200,
    parameter int data_bits   = 8,
    parameter int parity_type = 0,
    parameter int stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_bits-1:0] tx_data_in,
    input  logic                 start,
    output logic                 tx,
    output logic                 tx_active,
    output logic                 done_tx,
    output logic                 tx_ready
);

    localparam int         CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
    localparam logic [3:0] LAST_DATA    = 4'(data_bits - 1);
    localparam logic       LAST_STOP    = (stop_bits == 2);

    if (data_bits < 5 || data_bits > 9 || stop_bits < 1 || stop_bits > 2 ||
        parity_type < PARITY_NONE || parity_type > PARITY_EVEN || CLKS_PER_BIT < 2) begin : g_bad_params
        $error("uart_tx_framer: illegal frame parameters");
    end

    function automatic logic parity_of(input logic [data_bits-1:0] word);
        if (parity_type == PARITY_ODD) begin
            return ~^word;
        end
        return ^word;
    endfunction

    tx_state_e            state, state_next;
    logic [data_bits-1:0] buf_data, shreg;
    logic                 buf_full, parity_bit, load_pending;
    logic                 tx_q, tx_next;
    logic [3:0]           bit_idx, bit_idx_next;
    logic                 stop_idx, stop_idx_next;
    logic                 accept, frame_start, shift_en, bit_end;

    assign accept    = start && !buf_full;
    assign tx        = tx_q;
    assign tx_active = (state != TX_IDLE);
    assign tx_ready  = !buf_full;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (frame_start),
        .bit_end (bit_end)
    );

    // Next state and next line level; tx is registered from tx_next so the
    // line changes exactly on the cycle the new bit begins.
    always_comb begin
        state_next    = state;
        tx_next       = tx_q;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        frame_start   = 1'b0;
        shift_en      = 1'b0;
        done_tx       = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_next = 1'b1;
                if (buf_full || accept) begin
                    state_next  = TX_START;
                    tx_next     = 1'b0;
                    frame_start = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_next   = TX_DATA;
                    tx_next      = shreg[0];
                    bit_idx_next = 4'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_DATA) begin
                        stop_idx_next = 1'b0;
                        if (parity_type != PARITY_NONE) begin
                            state_next = TX_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = TX_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        shift_en     = 1'b1;
                        tx_next      = shreg[1];
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_next    = TX_STOP;
                    tx_next       = 1'b1;
                    stop_idx_next = 1'b0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (stop_idx == LAST_STOP) begin
                        done_tx = 1'b1;
                        // A queued (or just-arriving) word starts with no idle gap.
                        if (buf_full || accept) begin
                            state_next  = TX_START;
                            tx_next     = 1'b0;
                            frame_start = 1'b1;
                        end else begin
                            state_next = TX_IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= TX_IDLE;
            tx_q         <= 1'b1;
            buf_full     <= 1'b0;
            load_pending <= 1'b0;
            bit_idx      <= 4'd0;
            stop_idx     <= 1'b0;
        end else begin
            state        <= state_next;
            tx_q         <= tx_next;
            load_pending <= frame_start;
            bit_idx      <= bit_idx_next;
            stop_idx     <= stop_idx_next;
            // The buffer drains on the first cycle of the start bit.
            if (accept) begin
                buf_full <= 1'b1;
            end else if (load_pending) begin
                buf_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data <= tx_data_in;
        end
        if (load_pending) begin
            shreg      <= buf_data;
            parity_bit <= parity_of(buf_data);
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Configurations: 0 = 8N1, 1 = 8O1, 2 = 8E1, 3 = 5N2
    for (genvar G = 0; G < 4; G++) begin : g_cfg
        localparam int DB = (G == 3) ? 5 : 8;
        localparam int PT = (G == 1) ? 1 : ((G == 2) ? 2 : 0);
        localparam int SB = (G == 3) ? 2 : 1;
        localparam int NB = 1 + DB + ((PT != 0) ? 1 : 0) + SB;
        localparam int FL = NB * CPB;
        // Hand-computed line bits of the directed frame, bit 0 = start bit.
        localparam logic [10:0] PAT = (G == 0) ? 11'b01101001010 :
                                      (G == 1) ? 11'b11101001010 :
                                      (G == 2) ? 11'b10101001010 : 11'b00011100110;
        localparam logic [7:0] WORD = (G == 3) ? 8'h13 : 8'hA5;

        logic          rst   = 1'b1;
        logic          start = 1'b0;
        logic [DB-1:0] tx_data_in = '0;
        logic          tx, tx_active, done_tx, tx_ready;
        bit            fin = 1'b0;

        uart_tx_framer #(
            .clk_freq(CLK_FREQ), .baud_rate(BAUD), .data_bits(DB),
            .parity_type(PT), .stop_bits(SB)
        ) dut (
            .clk(clk), .rst(rst), .tx_data_in(tx_data_in), .start(start),
            .tx(tx), .tx_active(tx_active), .done_tx(done_tx), .tx_ready(tx_ready)
        );

        // Reference model: the line is a queue of per-cycle levels; the
        // buffer is a flag plus word.
        bit            line[$];
        bit            pend = 1'b0, clear_next = 1'b0, mvalid = 1'b0;
        logic [DB-1:0] pword = '0;
        bit            exp_tx = 1'b1, exp_act = 1'b0, exp_done = 1'b0, exp_rdy = 1'b1;

        function automatic void push_bit(input bit v);
            for (int k = 0; k < CPB; k++) line.push_back(v);
        endfunction

        initial forever begin
            bit acc;
            @(posedge clk);
            if (rst) begin
                line.delete();
                pend       = 1'b0;
                clear_next = 1'b0;
                mvalid     = 1'b1;
            end else if (mvalid) begin
                acc = start && !pend;
                if (clear_next) begin
                    pend       = 1'b0;
                    clear_next = 1'b0;
                end
                if (acc) begin
                    pend  = 1'b1;
                    pword = tx_data_in;
                end
                if (line.size() != 0) void'(line.pop_front());
                if (line.size() == 0 && pend && !clear_next) begin
                    push_bit(1'b0);
                    for (int i = 0; i < DB; i++) push_bit(pword[i]);
                    if (PT == 1) push_bit(($countones(pword) % 2) == 0);
                    if (PT == 2) push_bit(($countones(pword) % 2) == 1);
                    for (int s = 0; s < SB; s++) push_bit(1'b1);
                    clear_next = 1'b1;
                end
            end
            exp_tx   = (line.size() != 0) ? line[0] : 1'b1;
            exp_act  = (line.size() != 0);
            exp_done = (line.size() == 1);
            exp_rdy  = !pend;
        end

        initial forever begin
            @(negedge clk);
            if (mvalid) begin
                chk($sformatf("cfg%0d tx", G), tx, exp_tx);
                chk($sformatf("cfg%0d tx_active", G), tx_active, exp_act);
                chk($sformatf("cfg%0d done_tx", G), done_tx, exp_done);
                chk($sformatf("cfg%0d tx_ready", G), tx_ready, exp_rdy);
            end
        end

        initial begin
            logic [10:0] pat_v;
            int gaps, lows, dones, acts;
            pat_v = PAT;
            repeat (3) @(negedge clk);
            chk($sformatf("cfg%0d reset tx", G), tx, 1);
            chk($sformatf("cfg%0d reset tx_ready", G), tx_ready, 1);
            chk($sformatf("cfg%0d reset tx_active", G), tx_active, 0);
            rst = 1'b0;
            repeat (3) @(negedge clk);

            // Directed single frame against literal bit pattern
            start = 1'b1; tx_data_in = DB'(WORD);
            for (int c = 1; c <= FL + 3; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 1) chk($sformatf("cfg%0d ready low at N+1", G), tx_ready, 0);
                if (c == 2) chk($sformatf("cfg%0d ready high at N+2", G), tx_ready, 1);
                if (c <= FL && ((c - 1) % CPB) == CPB / 2)
                    chk($sformatf("cfg%0d frame bit %0d", G, (c - 1) / CPB), tx, pat_v[(c - 1) / CPB]);
                if (c == FL - 1) chk($sformatf("cfg%0d done before end", G), done_tx, 0);
                if (c == FL) chk($sformatf("cfg%0d done at end", G), done_tx, 1);
                if (c == FL + 1) chk($sformatf("cfg%0d active after end", G), tx_active, 0);
            end

            // Back-to-back frames with a third, ignored start
            gaps = 0;
            start = 1'b1; tx_data_in = DB'(8'h55);
            for (int c = 1; c <= 2 * FL + 3; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 5) begin
                    chk($sformatf("cfg%0d b2b ready at 5", G), tx_ready, 1);
                    start = 1'b1; tx_data_in = DB'(8'h0F);
                end
                if (c == 20) begin
                    chk($sformatf("cfg%0d b2b ready at 20", G), tx_ready, 0);
                    start = 1'b1; tx_data_in = DB'(8'h77);
                end
                if (c <= 2 * FL && !tx_active) gaps++;
                if (c == FL) chk($sformatf("cfg%0d b2b first done", G), done_tx, 1);
                if (c == FL + 1) chk($sformatf("cfg%0d b2b second start bit", G), tx, 0);
                if (c == 2 * FL) chk($sformatf("cfg%0d b2b second done", G), done_tx, 1);
                if (c == 2 * FL + 1) chk($sformatf("cfg%0d b2b no third frame", G), tx_active, 0);
            end
            chk($sformatf("cfg%0d b2b idle gaps", G), gaps, 0);

            // Reset mid-DATA with a queued word
            repeat (3) @(negedge clk);
            start = 1'b1; tx_data_in = DB'(8'h3C);
            lows = 0; dones = 0; acts = 0;
            for (int c = 1; c <= 2 * FL + 20; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 5) begin start = 1'b1; tx_data_in = DB'(8'h99); end
                if (c == 45) rst = 1'b1;
                if (c == 46) begin
                    rst = 1'b0;
                    chk($sformatf("cfg%0d rst tx", G), tx, 1);
                    chk($sformatf("cfg%0d rst tx_active", G), tx_active, 0);
                    chk($sformatf("cfg%0d rst tx_ready", G), tx_ready, 1);
                end
                if (c >= 46) begin
                    if (!tx) lows++;
                    if (done_tx) dones++;
                    if (tx_active) acts++;
                end
            end
            chk($sformatf("cfg%0d after rst tx low cycles", G), lows, 0);
            chk($sformatf("cfg%0d after rst done pulses", G), dones, 0);
            chk($sformatf("cfg%0d after rst active cycles", G), acts, 0);

            // Randomized traffic with occasional resets
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                start      = ($urandom_range(0, 7) == 0);
                tx_data_in = DB'($urandom);
                rst        = ($urandom_range(0, 1999) == 0);
            end
            @(negedge clk);
            start = 1'b0; rst = 1'b0;
            repeat (2 * FL) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int i = 0; i < 20000 && !all_fin; i++) begin
            @(posedge clk);
            all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;
        end
        chk("all scenarios completed within budget", all_fin, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Configurable UART transmitter that serialises a parallel word into an asynchronous frame: start bit, 5–9 data bits LSB first, optional odd/even parity, then 1 or 2 stop bits. It honours the full frame parameter set (`data_bits`, `parity_type`, `stop_bits`), and adds a one-entry holding buffer so the host can queue the next word while the current frame is on the line. It pairs with the UART receiver as the transmit end of the link, and slots into the `uart` top in place of the fixed-format transmitter.

## Interface
- `clk_freq`, 50000000: system clock in Hz.
- `baud_rate`, 19200: bits per second.
- `data_bits`, 8: data width, 5–9.
- `parity_type`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: 1 or 2.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `tx_data_in` input `data_bits`: word to send; sampled when `start` is accepted.
- `start` input 1: send request; accepted only when `tx_ready`=1.
- `tx` output 1: serial line; idle high.
- `tx_active` output 1: frame in progress on the line.
- `done_tx` output 1: one-cycle pulse at frame end.
- `tx_ready` output 1: holding buffer empty; a new `start` will be accepted.

## Operation
- `CLKS_PER_BIT` = `clk_freq`/`baud_rate`, integer-truncated (2604 at defaults).
- `NBITS` = 1 + `data_bits` + (`parity_type`≠0) + `stop_bits`.
- Frame length = `CLKS_PER_BIT`×`NBITS` cycles.
- Bit counter is `$clog2(CLKS_PER_BIT)` wide.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: buffer full.
  - START → DATA: after `CLKS_PER_BIT` cycles.
  - DATA → PARITY or STOP: after `data_bits` bit periods.
  - PARITY → STOP: after one bit period.
  - STOP → IDLE, or STOP → START if the buffer is full.
- Parity is computed over the transmitted word at load.
  - Odd: parity bit makes the total count of ones (data + parity) odd.
  - Even: parity bit makes that count even.
- Holding buffer:
  - `start` with `tx_ready`=1 loads `tx_data_in` and clears `tx_ready`.
  - Loading into the shift register at the START entry empties the buffer.
  - `start` with `tx_ready`=0 is ignored; no error flag.
- Illegal parameters (`data_bits` outside 5–9, `stop_bits` outside 1–2, `parity_type`>2) are rejected by an elaboration-time check.

## Timing
- Reset values: `tx`=1, `tx_active`=0, `done_tx`=0, `tx_ready`=1, state IDLE, buffer empty.
- Reset mid-frame: `tx`=1 on the next cycle; the frame is aborted, the buffer is discarded, and `done_tx` does not pulse.
- Latency: `start` accepted in idle at cycle N → `tx`=0 and `tx_active`=1 from cycle N+1.
- `tx_ready` is low at N+1, then high again at N+2 after the buffer moves to the shift register.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- `done_tx`=1 for exactly the final cycle of the last stop bit.
- Back-to-back frames: with a queued word, the next start bit begins on the cycle after `done_tx`. `tx_active` stays 1 and there is no idle gap.
- No queued word: `tx_active`=0 on the cycle after `done_tx`.
- Simultaneous `start` and buffer drain (`tx_ready` already 1): accepted normally.
- `tx` is a registered output; it is glitch-free.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_e` enum.
  - Parity constants `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN`.
  - Function `clks_per_bit(clk_freq, baud_rate)`, reused by the receiver.
- Sub-module `uart_baud_tick`: free-running divider, restarted on frame start, emits a one-cycle `bit_end` pulse every `CLKS_PER_BIT` cycles.
- FSM, shift register and holding buffer live in `uart_tx_framer`.

## Test plan
All scenarios use `clk_freq`=1000000 and `baud_rate`=100000, so `CLKS_PER_BIT`=10.
- 8N1, send 0xA5 at cycle 0.
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles over cycles 1–100.
  - `done_tx` at cycle 100; `tx_active`=0 at 101.
- 8O1, send 0xA5: parity bit 1, 110-cycle frame. 8E1, same word: parity bit 0.
- 5N2, send 0x13: bits 0,1,1,0,0,1,1,1; frame is 80 cycles.
- Back-to-back: send 0x55, then `start` with 0x0F at cycle 5 (`tx_ready`=1 at cycle 5).
  - Second start bit at cycle 101; `done_tx` at 100 and 200; `tx_active` continuously 1.
  - A third `start` at cycle 20, while `tx_ready`=0, is ignored.
- Reset: assert `rst` at cycle 45 mid-DATA with a queued word.
  - Cycle 46: `tx`=1, `tx_active`=0, `tx_ready`=1.
  - No `done_tx` pulse; no further frame is sent.
